axi_crossbar_addr_arb: RTL
==========================

Name: axi_crossbar_addr_arb

Overview:
Per-master-interface address-channel arbiter for the AXI crossbar. It collects decoded address requests from S_COUNT slave-side address decoders that target one master interface, and grants exactly one of them. Selection is QoS-aware round-robin. It drives the master-side address valid/ready handshake and limits outstanding transactions to M_ISSUE. It records the source of every issued transaction in an in-order FIFO so that responses can be routed back to the correct requester.

Parameters:
S_COUNT, 4, number of requesters (slave interfaces); must be ≥1.
M_ISSUE, 4, maximum outstanding transactions on this master interface; must be ≥1.
CL_S_COUNT, $clog2(S_COUNT) (minimum 1), width of the encoded grant.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_req_valid  in  S_COUNT  per-requester request; held high until its s_req_ready pulse
s_req_qos  in  S_COUNT*4  per-requester AxQOS; field k at [k*4 +: 4]
s_req_ready  out  S_COUNT  one-hot, one-cycle acceptance pulse
m_grant  out  S_COUNT  one-hot current grant (mux select for address fields)
m_grant_encoded  out  CL_S_COUNT  binary index of the current grant
m_grant_valid  out  1  grant held
m_axi_avalid  out  1  master address valid
m_axi_aready  in  1  master address ready
m_cpl_valid  in  1  one transaction completed (B beat, or last R beat)
m_cpl_src  out  CL_S_COUNT  source index at the head of the outstanding FIFO
m_cpl_err  out  1  one-cycle pulse: completion received with no transaction outstanding
m_issue_count  out  $clog2(M_ISSUE+1)  current outstanding count

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - all outputs, with m_grant_encoded = 0 and m_cpl_src = 0;
  - state = IDLE;
  - FIFO pointers;
  - issue count;
  - round-robin pointer = 0.
- Reset mid-operation abandons any in-flight grant. No s_req_ready pulse is emitted.
- FSM has two states, IDLE and ISSUE.
- IDLE:
  - Grant condition, evaluated in cycle N: any s_req_valid is high, and (issue_count < M_ISSUE, or m_cpl_valid is high in the same cycle with issue_count = M_ISSUE).
  - When the condition holds, the winner is registered. In cycle N+1: m_grant, m_grant_encoded and m_grant_valid are set, m_axi_avalid = 1, and the state is ISSUE.
- Winner selection:
  - Candidates are the valid requesters with the maximum QoS value (with ARB_QOS_EN); otherwise all valid requesters.
  - Among the candidates, pick the first index at or after rr_ptr, wrapping modulo S_COUNT.
  - On grant, rr_ptr = winner+1, wrapping from S_COUNT-1 to 0.
- Admission (at grant time):
  - Push the winner index into the FIFO and increment issue_count.
  - A same-cycle completion pops the FIFO and leaves the count unchanged.
- ISSUE:
  - m_axi_avalid is held, and the grant is stable, until m_axi_aready is high (cycle K).
  - In cycle K+1: m_axi_avalid = 0, m_grant_valid = 0, m_grant = 0, s_req_ready[winner] = 1 for exactly one cycle, and the state is IDLE.
  - Requests are not re-sampled in cycle K+1 (the requester drops valid). The earliest next grant is registered in cycle K+2.
- Completions:
  - m_cpl_valid with issue_count > 0: pop the FIFO and decrement the count (unless a same-cycle grant occurs).
  - m_cpl_valid with issue_count = 0: ignored; m_cpl_err pulses for one cycle.
- m_cpl_src is the FIFO head, valid whenever issue_count > 0; otherwise it is 0.
- FIFO depth is M_ISSUE. Pointers wrap modulo M_ISSUE. Overflow is impossible by the admission rule.
- A valid requester that is not granted is never starved: round-robin guarantees service within S_COUNT grants among equal QoS.

Optional Feature:
Macro: AXI_CROSSBAR_ARB_QOS_EN.
- Defined: the highest s_req_qos among valid requesters wins; round-robin breaks ties only.
- Undefined: s_req_qos is ignored and arbitration is pure round-robin. The s_req_qos port is still present and unused.

Test Plan:
- Reset, then single request s_req_valid=4'b0100, aready tied high -> m_axi_avalid and m_grant=4'b0100 in cycle N+1; s_req_ready=4'b0100 pulse in N+2; m_issue_count=1; m_cpl_src=2.
- All four requesters valid at equal QoS, aready high, completions returned immediately -> grants in order 0,1,2,3,0; each grant spaced 3 cycles apart.
- With AXI_CROSSBAR_ARB_QOS_EN: requester 1 QoS=3, requester 3 QoS=9, both valid -> grant 3 first, then 1. Without the macro -> grant 1 first.
- M_ISSUE=4, no completions, continuous requests -> four grants, then m_grant_valid stays 0. Assert m_cpl_valid -> m_cpl_src equals the first-granted source, and a new grant is registered in the next cycle.
- Hold m_axi_aready low for 5 cycles -> m_axi_avalid and m_grant are stable and no s_req_ready pulses. Then assert rst_n=0 -> all outputs are 0 immediately and m_issue_count=0.
- m_cpl_valid with nothing outstanding -> m_cpl_err one-cycle pulse; count remains 0.

Source files
------------

// File: rtl/axi_crossbar_addr_arb.sv
// -----------------------------------------------------------------------------
// axi_crossbar_addr_arb
//
// Address-channel arbiter for one master interface of an AXI crossbar.
// Collects decoded address requests from S_COUNT slave-side decoders, grants
// one of them (QoS-aware round-robin), drives the master address handshake,
// caps outstanding transactions at M_ISSUE, and keeps an in-order FIFO of
// granted sources so responses can be steered back to their requester.
//
// Optional feature macro: AXI_CROSSBAR_ARB_QOS_EN
//   defined   : highest s_req_qos among valid requesters wins, round-robin
//               only breaks ties.
//   undefined : s_req_qos is ignored, pure round-robin.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_req_valid       per-requester request, held until its s_req_ready pulse
//   s_req_qos         per-requester AxQOS, field k at [k*4 +: 4]
//   s_req_ready       one-hot, one-cycle acceptance pulse
//   m_grant           one-hot current grant (address mux select)
//   m_grant_encoded   binary index of the current grant
//   m_grant_valid     grant held
//   m_axi_avalid      master address valid
//   m_axi_aready      master address ready
//   m_cpl_valid       one transaction completed (B beat or last R beat)
//   m_cpl_src         source index at the head of the outstanding FIFO
//   m_cpl_err         one-cycle pulse: completion with nothing outstanding
//   m_issue_count     current outstanding count
//   dbg_state         FSM state (0 = IDLE, 1 = ISSUE)
//
// Handshake semantics: m_axi_avalid rises with a registered grant and stays
// high with a stable grant until m_axi_aready is sampled high; the cycle after
// that, avalid/grant drop and s_req_ready pulses for the winner. A requester
// holds s_req_valid until it sees its s_req_ready pulse, then drops it. The
// pulse cycle itself is never used for arbitration, so a requester still
// showing valid in that cycle cannot be granted twice.
// -----------------------------------------------------------------------------
module axi_crossbar_addr_arb #(
  parameter int S_COUNT = 4,
  parameter int M_ISSUE = 4,
  localparam int CL_S_COUNT = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
  localparam int CNT_W = $clog2(M_ISSUE + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_COUNT-1:0]      s_req_valid,
  input  logic [S_COUNT*4-1:0]    s_req_qos,
  output logic [S_COUNT-1:0]      s_req_ready,
  output logic [S_COUNT-1:0]      m_grant,
  output logic [CL_S_COUNT-1:0]   m_grant_encoded,
  output logic                    m_grant_valid,
  output logic                    m_axi_avalid,
  input  logic                    m_axi_aready,
  input  logic                    m_cpl_valid,
  output logic [CL_S_COUNT-1:0]   m_cpl_src,
  output logic                    m_cpl_err,
  output logic [CNT_W-1:0]        m_issue_count,
  output logic                    dbg_state
);

  localparam int PTR_W = (M_ISSUE > 1) ? $clog2(M_ISSUE) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [S_COUNT-1:0]      s_req_ready_q, s_req_ready_d;
  logic [S_COUNT-1:0]      m_grant_q, m_grant_d;
  logic [CL_S_COUNT-1:0]   m_grant_encoded_q, m_grant_encoded_d;
  logic                    m_grant_valid_q, m_grant_valid_d;
  logic                    m_axi_avalid_q, m_axi_avalid_d;
  logic                    m_cpl_err_q, m_cpl_err_d;
  logic [CNT_W-1:0]        issue_count_q, issue_count_d;
  logic [CL_S_COUNT-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CL_S_COUNT-1:0]   fifo_q [M_ISSUE];

  // ---------------------------------------------------------------------------
  // Candidate selection
  // ---------------------------------------------------------------------------
  logic [S_COUNT-1:0] cand;

`ifdef AXI_CROSSBAR_ARB_QOS_EN
  logic [3:0] max_qos;

  // Only requesters carrying the highest QoS among the valid set compete.
  always_comb begin
    max_qos = 4'd0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (s_req_valid[i] && (s_req_qos[i*4 +: 4] > max_qos)) begin
        max_qos = s_req_qos[i*4 +: 4];
      end
    end
    cand = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      cand[i] = s_req_valid[i] && (s_req_qos[i*4 +: 4] == max_qos);
    end
  end
`else
  logic unused_qos;

  assign unused_qos = ^s_req_qos;

  always_comb begin
    cand = s_req_valid;
  end
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick: first candidate at or after rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  logic [CL_S_COUNT-1:0] win_idx;
  logic                  win_found;

  always_comb begin
    int idx;
    win_idx   = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int i = 0; i < S_COUNT; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= S_COUNT) begin
        idx = idx - S_COUNT;
      end
      if (!win_found && cand[CL_S_COUNT'(idx)]) begin
        win_found = 1'b1;
        win_idx   = CL_S_COUNT'(idx);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic grant_ok;
  logic push;
  logic pop;

  always_comb begin
    state_d           = state_q;
    s_req_ready_d     = '0;
    m_grant_d         = m_grant_q;
    m_grant_encoded_d = m_grant_encoded_q;
    m_grant_valid_d   = m_grant_valid_q;
    m_axi_avalid_d    = m_axi_avalid_q;
    rr_ptr_d          = rr_ptr_q;
    push              = 1'b0;

    // A completion arriving while the FIFO is full frees a slot in the same
    // cycle, so admission may proceed at the limit.
    grant_ok = (state_q == ST_IDLE) && (s_req_ready_q == '0) && win_found &&
               ((issue_count_q < CNT_W'(M_ISSUE)) ||
                (m_cpl_valid && (issue_count_q == CNT_W'(M_ISSUE))));

    pop         = m_cpl_valid && (issue_count_q != '0);
    m_cpl_err_d = m_cpl_valid && (issue_count_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (grant_ok) begin
          state_d           = ST_ISSUE;
          m_grant_d         = S_COUNT'(1) << win_idx;
          m_grant_encoded_d = win_idx;
          m_grant_valid_d   = 1'b1;
          m_axi_avalid_d    = 1'b1;
          rr_ptr_d          = (win_idx == CL_S_COUNT'(S_COUNT - 1)) ? '0 : win_idx + 1'b1;
          push              = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (m_axi_aready) begin
          state_d         = ST_IDLE;
          m_axi_avalid_d  = 1'b0;
          m_grant_valid_d = 1'b0;
          m_grant_d       = '0;
          s_req_ready_d   = m_grant_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    issue_count_d = issue_count_q + CNT_W'(push) - CNT_W'(pop);

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(M_ISSUE - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(M_ISSUE - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      s_req_ready_q     <= '0;
      m_grant_q         <= '0;
      m_grant_encoded_q <= '0;
      m_grant_valid_q   <= 1'b0;
      m_axi_avalid_q    <= 1'b0;
      m_cpl_err_q       <= 1'b0;
      issue_count_q     <= '0;
      rr_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      for (int i = 0; i < M_ISSUE; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q           <= state_d;
      s_req_ready_q     <= s_req_ready_d;
      m_grant_q         <= m_grant_d;
      m_grant_encoded_q <= m_grant_encoded_d;
      m_grant_valid_q   <= m_grant_valid_d;
      m_axi_avalid_q    <= m_axi_avalid_d;
      m_cpl_err_q       <= m_cpl_err_d;
      issue_count_q     <= issue_count_d;
      rr_ptr_q          <= rr_ptr_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      // When full with a same-cycle pop, wr_ptr equals rd_ptr: the head is
      // being retired this cycle, so overwriting its slot is safe.
      if (push) begin
        fifo_q[wr_ptr_q] <= win_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_req_ready     = s_req_ready_q;
  assign m_grant         = m_grant_q;
  assign m_grant_encoded = m_grant_encoded_q;
  assign m_grant_valid   = m_grant_valid_q;
  assign m_axi_avalid    = m_axi_avalid_q;
  assign m_cpl_err       = m_cpl_err_q;
  assign m_issue_count   = issue_count_q;
  assign m_cpl_src       = (issue_count_q != '0) ? fifo_q[rd_ptr_q] : '0;
  assign dbg_state       = (state_q == ST_ISSUE);

endmodule
